// File: rtl/mult_job_arbiter.sv
// Round-robin arbiter that shares one shift-add multiplier between N_REQ requesters,
// sequencing load/run, waiting for done under a timeout and returning the product.
//
// state | meaning
// IDLE  | scan requesters from ptr, accept the first valid job
// LOAD  | pulse Mult_Ld with the latched operands on Mult_B/Mult_X
// START | pulse Mult_Run, clear the wait timer
// WAIT  | wait for Mult_Done or timeout
// RESP  | present the result to the granted requester until it accepts
module mult_job_arbiter #(
  parameter int W       = 8,
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 32
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [N_REQ-1:0]   Req_Valid,
  input  logic [N_REQ*W-1:0] Req_A,
  input  logic [N_REQ*W-1:0] Req_X,
  output logic [N_REQ-1:0]   Req_Ready,
  output logic [N_REQ-1:0]   Resp_Valid,
  input  logic [N_REQ-1:0]   Resp_Ready,
  output logic [2*W-1:0]     Resp_Data,
  output logic               Resp_Err,
  output logic               Mult_Ld,
  output logic               Mult_Run,
  output logic [W-1:0]       Mult_B,
  output logic [W-1:0]       Mult_X,
  input  logic [2*W-1:0]     Mult_Result,
  input  logic               Mult_Done,
  output logic               Busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]     state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  grant_idx;
  logic [W-1:0]   mult_b;
  logic [W-1:0]   mult_x;
  logic [TW-1:0]  timer;
  logic [2*W-1:0] resp_data;
  logic           resp_err;

  logic           win_found;
  logic [PW-1:0]  win_idx;
  logic [PW:0]    cand;
  logic [PW-1:0]  ptr_next;

  // Rotating scan: candidate k is (ptr + k) mod N_REQ, first valid one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(N_REQ)) cand = cand - (PW+1)'(N_REQ);
      if (!win_found && Req_Valid[cand[PW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PW-1:0];
      end
    end
  end

  assign ptr_next = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + PW'(1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      mult_b    <= '0;
      mult_x    <= '0;
      timer     <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            mult_b    <= Req_A[win_idx*W +: W];
            mult_x    <= Req_X[win_idx*W +: W];
            grant_idx <= win_idx;
            state     <= S_LOAD;
          end
        end
        S_LOAD: state <= S_START;
        S_START: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          timer <= timer + TW'(1);
          // Done takes priority over a coincident timeout.
          if (Mult_Done) begin
            resp_data <= Mult_Result;
            resp_err  <= 1'b0;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT-1)) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (Resp_Ready[grant_idx]) begin
            ptr   <= ptr_next;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gated by reset so no grant is advertised while the block is held in reset.
  assign Req_Ready  = (Reset_n && state == S_IDLE && win_found) ? (N_REQ'(1) << win_idx) : '0;
  assign Resp_Valid = (state == S_RESP) ? (N_REQ'(1) << grant_idx) : '0;
  assign Resp_Data  = resp_data;
  assign Resp_Err   = resp_err;
  assign Mult_Ld    = (state == S_LOAD);
  assign Mult_Run   = (state == S_START);
  assign Mult_B     = mult_b;
  assign Mult_X     = mult_x;
  assign Busy       = (state != S_IDLE);

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Directed bench for mult_job_arbiter; the bench itself plays the multiplier,
// driving Mult_Done/Mult_Result at chosen cycles.
module tb_mult_job_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic [1:0]  Req_Valid;
  logic [15:0] Req_A;
  logic [15:0] Req_X;
  logic [1:0]  Req_Ready;
  logic [1:0]  Resp_Valid;
  logic [1:0]  Resp_Ready;
  logic [15:0] Resp_Data;
  logic        Resp_Err;
  logic        Mult_Ld;
  logic        Mult_Run;
  logic [7:0]  Mult_B;
  logic [7:0]  Mult_X;
  logic [15:0] Mult_Result;
  logic        Mult_Done;
  logic        Busy;

  int total = 0;
  int bad   = 0;

  mult_job_arbiter #(.W(8), .N_REQ(2), .TIMEOUT(32)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .Req_Valid(Req_Valid), .Req_A(Req_A), .Req_X(Req_X), .Req_Ready(Req_Ready),
    .Resp_Valid(Resp_Valid), .Resp_Ready(Resp_Ready), .Resp_Data(Resp_Data), .Resp_Err(Resp_Err),
    .Mult_Ld(Mult_Ld), .Mult_Run(Mult_Run), .Mult_B(Mult_B), .Mult_X(Mult_X),
    .Mult_Result(Mult_Result), .Mult_Done(Mult_Done), .Busy(Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req_ready"},  32'(Req_Ready),  32'h0);
    check({tag, " resp_valid"}, 32'(Resp_Valid), 32'h0);
    check({tag, " resp_data"},  32'(Resp_Data),  32'h0);
    check({tag, " resp_err"},   32'(Resp_Err),   32'h0);
    check({tag, " mult_ld"},    32'(Mult_Ld),    32'h0);
    check({tag, " mult_run"},   32'(Mult_Run),   32'h0);
    check({tag, " mult_b"},     32'(Mult_B),     32'h0);
    check({tag, " mult_x"},     32'(Mult_X),     32'h0);
    check({tag, " busy"},       32'(Busy),       32'h0);
  endtask

  // Runs one job from an IDLE cycle: accept, LOAD, START, WAIT, RESP, return to IDLE.
  // done_after = cycles after Run at which Mult_Done pulses (0 = never).
  task automatic do_job(input string name, input logic [1:0] valid,
                        input logic [7:0] a0, input logic [7:0] x0,
                        input logic [7:0] a1, input logic [7:0] x1,
                        input int done_after, input logic [15:0] result,
                        input logic [1:0] exp_grant, input logic [15:0] exp_data,
                        input logic exp_err, input int hold);
    logic [7:0] exp_b;
    logic [7:0] exp_x;
    int dc;
    exp_b = exp_grant[1] ? a1 : a0;
    exp_x = exp_grant[1] ? x1 : x0;
    dc = 2 + done_after;
    Req_Valid = valid;
    Req_A = {a1, a0};
    Req_X = {x1, x0};
    #1;
    check({name, " accept req_ready"}, 32'(Req_Ready), 32'(exp_grant));
    check({name, " accept busy"}, 32'(Busy), 32'h0);
    tick();
    check({name, " load mult_ld"}, 32'(Mult_Ld), 32'h1);
    check({name, " load mult_run"}, 32'(Mult_Run), 32'h0);
    check({name, " load req_ready"}, 32'(Req_Ready), 32'h0);
    check({name, " load mult_b"}, 32'(Mult_B), 32'(exp_b));
    check({name, " load mult_x"}, 32'(Mult_X), 32'(exp_x));
    tick();
    check({name, " start mult_run"}, 32'(Mult_Run), 32'h1);
    check({name, " start mult_ld"}, 32'(Mult_Ld), 32'h0);
    tick();
    for (int c = 3; c < 3 + 32; c++) begin
      if (done_after > 0 && c == dc) begin
        Mult_Done = 1'b1;
        Mult_Result = result;
      end
      #1;
      check({name, " wait resp_valid"}, 32'(Resp_Valid), 32'h0);
      check({name, " wait mult_b"}, 32'(Mult_B), 32'(exp_b));
      check({name, " wait mult_x"}, 32'(Mult_X), 32'(exp_x));
      check({name, " wait busy"}, 32'(Busy), 32'h1);
      tick();
      Mult_Done = 1'b0;
      Mult_Result = 16'hDEAD;
      if (done_after > 0 && c == dc) break;
    end
    #1;
    check({name, " resp_valid"}, 32'(Resp_Valid), 32'(exp_grant));
    check({name, " resp_data"}, 32'(Resp_Data), 32'(exp_data));
    check({name, " resp_err"}, 32'(Resp_Err), 32'(exp_err));
    Resp_Ready = ~exp_grant;
    for (int h = 0; h < hold; h++) begin
      tick();
      #1;
      check({name, " hold resp_valid"}, 32'(Resp_Valid), 32'(exp_grant));
      check({name, " hold resp_data"}, 32'(Resp_Data), 32'(exp_data));
      check({name, " hold req_ready"}, 32'(Req_Ready), 32'h0);
    end
    Resp_Ready = exp_grant;
    tick();
    Resp_Ready = 2'b00;
    #1;
    check({name, " done resp_valid"}, 32'(Resp_Valid), 32'h0);
    check({name, " done busy"}, 32'(Busy), 32'h0);
  endtask

  initial begin
    Reset_n = 1'b0;
    Req_Valid = 2'b00;
    Req_A = 16'h0;
    Req_X = 16'h0;
    Resp_Ready = 2'b00;
    Mult_Result = 16'hDEAD;
    Mult_Done = 1'b0;
    tick();
    check_all_zero("reset");
    tick();
    Reset_n = 1'b1;
    tick();

    // Basic job, done 8 cycles after Run
    do_job("t1", 2'b01, 8'h07, 8'h03, 8'h00, 8'h00, 8, 16'h0015, 2'b01, 16'h0015, 1'b0, 0);

    // Signed operands through requester 1 (leaves ptr at 0)
    do_job("t2", 2'b10, 8'h00, 8'h00, 8'hFB, 8'h04, 3, 16'hFFEC, 2'b10, 16'hFFEC, 1'b0, 0);

    // Both requesters continuously valid: strict rotation 0,1,0,1
    do_job("t3a", 2'b11, 8'h02, 8'h03, 8'h04, 8'h05, 2, 16'h0006, 2'b01, 16'h0006, 1'b0, 0);
    do_job("t3b", 2'b11, 8'h02, 8'h03, 8'h04, 8'h05, 4, 16'h0014, 2'b10, 16'h0014, 1'b0, 0);
    do_job("t3c", 2'b11, 8'h06, 8'h07, 8'h08, 8'h09, 1, 16'h002A, 2'b01, 16'h002A, 1'b0, 0);
    do_job("t3d", 2'b11, 8'h06, 8'h07, 8'hFF, 8'hFF, 6, 16'h0001, 2'b10, 16'h0001, 1'b0, 0);

    // Timeout with no done, then a normal job
    do_job("t4", 2'b01, 8'h0A, 8'h0B, 8'h00, 8'h00, 0, 16'h0000, 2'b01, 16'h0000, 1'b1, 0);
    do_job("t4n", 2'b10, 8'h00, 8'h00, 8'h03, 8'h05, 5, 16'h000F, 2'b10, 16'h000F, 1'b0, 0);

    // Done coincides with the timeout cycle; response stalled 5 cycles
    do_job("t5", 2'b11, 8'h12, 8'h34, 8'h56, 8'h78, 32, 16'h1234, 2'b01, 16'h1234, 1'b0, 5);

    // Reset during WAIT drops the job; ptr (1 before reset) returns to 0
    Req_Valid = 2'b01;
    Req_A = 16'h0011;
    Req_X = 16'h0022;
    #1;
    check("t6 accept req_ready", 32'(Req_Ready), 32'h1);
    tick();
    tick();
    tick();
    tick();
    check("t6 in wait busy", 32'(Busy), 32'h1);
    Reset_n = 1'b0;
    Mult_Done = 1'b1;
    Mult_Result = 16'h5555;
    #1;
    check_all_zero("t6 rst");
    tick();
    check_all_zero("t6 rst2");
    Reset_n = 1'b1;
    Mult_Done = 1'b0;
    Mult_Result = 16'hDEAD;
    Req_Valid = 2'b00;
    #1;
    check("t6 post busy", 32'(Busy), 32'h0);
    check("t6 post resp_valid", 32'(Resp_Valid), 32'h0);
    Req_Valid = 2'b11;
    #1;
    check("t6 ptr reset grant", 32'(Req_Ready), 32'h1);
    Req_Valid = 2'b00;
    tick();
    do_job("t6", 2'b10, 8'h00, 8'h00, 8'h09, 8'h02, 3, 16'h0012, 2'b10, 16'h0012, 1'b0, 0);

    Req_Valid = 2'b00;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
